// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage RAW/load-use detection, taken-branch flush and HLT drain.
// Define HAZARD_CTRL_FWD_EN to enable EX operand forwarding selects.
module hazard_ctrl #(
  parameter int unsigned FWD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_rs0,
  input  logic [3:0] id_rs1,
  input  logic       id_rs0_used,
  input  logic       id_rs1_used,
  input  logic [3:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_load,
  input  logic       id_halt,
  input  logic       branch_taken,
  output logic       stall,
  output logic       bubble_ex,
  output logic       flush_ifid,
  output logic [1:0] fwd_reg0,
  output logic [1:0] fwd_reg1,
  output logic       halted
);
  localparam int unsigned REG_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 2;
  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             load;
  } prod_t;

  typedef enum logic [2:0] {RUN, LDSTALL, BRFLUSH, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  prod_t            ex_q, ex_d, mem_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_c, bubble_c, flush_c;
  logic             id_act, raw_c;
  logic             ex_hit0, ex_hit1, mem_hit0, mem_hit1;
  logic             unused_load;

  function automatic logic hit(input logic used, input logic [REG_W-1:0] rs, input prod_t p);
    return used && (rs == p.rd) && p.regwrite && (p.rd != REG_W'(0));
  endfunction

  // ID content is only meaningful while the pipeline is running normally
  assign id_act   = id_valid && ((state_q == RUN) || (state_q == LDSTALL));
  assign ex_hit0  = id_act && hit(id_rs0_used, id_rs0, ex_q);
  assign ex_hit1  = id_act && hit(id_rs1_used, id_rs1, ex_q);
  assign mem_hit0 = id_act && hit(id_rs0_used, id_rs0, mem_q);
  assign mem_hit1 = id_act && hit(id_rs1_used, id_rs1, mem_q);

`ifdef HAZARD_CTRL_FWD_EN
  localparam state_t RAW_NEXT = LDSTALL;
  localparam int unsigned UNUSED_LAT = FWD_LAT;
  localparam logic [SEL_W-1:0] SEL_ALU = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

  logic [SEL_W-1:0] fwd0_q, fwd0_d, fwd1_q, fwd1_d;

  function automatic logic [SEL_W-1:0] pick(input logic ex_hit, input logic mem_hit,
                                            input logic ex_load);
    if (ex_hit && !ex_load) return SEL_ALU;
    if (mem_hit) return SEL_WB;
    return SEL_RF;
  endfunction

  assign raw_c  = ex_q.load && (ex_hit0 || ex_hit1);
  assign fwd0_d = bubble_c ? SEL_RF : pick(ex_hit0, mem_hit0, ex_q.load);
  assign fwd1_d = bubble_c ? SEL_RF : pick(ex_hit1, mem_hit1, ex_q.load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd0_q <= SEL_RF;
      fwd1_q <= SEL_RF;
    end else begin
      fwd0_q <= fwd0_d;
      fwd1_q <= fwd1_d;
    end
  end

  assign fwd_reg0    = fwd0_q;
  assign fwd_reg1    = fwd1_q;
  assign unused_load = mem_q.load;
`else
  localparam state_t RAW_NEXT = RUN;
  localparam int unsigned EXT_W = (FWD_LAT > 1) ? $clog2(FWD_LAT) : 1;
  localparam logic [EXT_W-1:0] EXT_INIT = EXT_W'(FWD_LAT - 1);

  logic [EXT_W-1:0] ext_q, ext_d;
  logic             dep_c;

  // Without forwarding, hold ID until the producer has left MEM, plus FWD_LAT-1 cycles
  assign dep_c = ex_hit0 || ex_hit1 || mem_hit0 || mem_hit1;
  assign raw_c = dep_c || (ext_q != '0);

  always_comb begin
    ext_d = ext_q;
    if (branch_taken || (state_q != RUN)) ext_d = '0;
    else if (dep_c)                       ext_d = EXT_INIT;
    else if (ext_q != '0)                 ext_d = ext_q - EXT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_q <= '0;
    else        ext_q <= ext_d;
  end

  assign fwd_reg0    = SEL_RF;
  assign fwd_reg1    = SEL_RF;
  assign unused_load = mem_q.load ^ ex_q.load;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      RUN, LDSTALL: begin
        state_d = RUN;
        if (branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = BRFLUSH;
        end else if (raw_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = RAW_NEXT;
        end else if (id_valid && id_halt) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = '0;
          state_d  = DRAIN;
        end
      end
      BRFLUSH: state_d = RUN;
      DRAIN: begin
        if (branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = '0;
          state_d  = BRFLUSH;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HALTED: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Producer pipeline: a bubble or non-running ID enters EX as a non-writer
  assign ex_d = (bubble_c || !id_act) ? '0 : '{rd: id_rd, regwrite: id_regwrite, load: id_load};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
    end
  end

  assign stall      = rst_n && stall_c;
  assign bubble_ex  = rst_n && bubble_c;
  assign flush_ifid = rst_n && flush_c;
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations follow HAZARD_CTRL_FWD_EN.
module tb_hazard_ctrl;
  logic       clk, rst_n, id_valid;
  logic [3:0] id_rs0, id_rs1, id_rd;
  logic       id_rs0_used, id_rs1_used, id_regwrite, id_load, id_halt, branch_taken;
  logic       stall, bubble_ex, flush_ifid, halted;
  logic [1:0] fwd_reg0, fwd_reg1;
  logic [3:0] ctl, fwd;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_STALL = 4'b1100;
  localparam logic [3:0] C_FLUSH = 4'b0110;
  localparam logic [3:0] C_HALT  = 4'b1101;

  hazard_ctrl #(.FWD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_rs0_used(id_rs0_used), .id_rs1_used(id_rs1_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load), .id_halt(id_halt),
    .branch_taken(branch_taken),
    .stall(stall), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
    .fwd_reg0(fwd_reg0), .fwd_reg1(fwd_reg1), .halted(halted)
  );

  assign ctl = {stall, bubble_ex, flush_ifid, halted};
  assign fwd = {fwd_reg0, fwd_reg1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs0 = 4'd0; id_rs1 = 4'd0; id_rs0_used = 1'b0; id_rs1_used = 1'b0;
    id_rd = 4'd0; id_regwrite = 1'b0; id_load = 1'b0; id_halt = 1'b0;
  endtask

  task automatic set_id(input logic [3:0] rs0, input logic u0, input logic [3:0] rs1,
                        input logic u1, input logic [3:0] rd, input logic rw,
                        input logic ld, input logic hlt);
    id_valid = 1'b1; id_rs0 = rs0; id_rs0_used = u0; id_rs1 = rs1; id_rs1_used = u1;
    id_rd = rd; id_regwrite = rw; id_load = ld; id_halt = hlt;
  endtask

  initial begin
    rst_n = 1'b0; branch_taken = 1'b0; idle();
    #2;
    branch_taken = 1'b1;
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("reset_ctl", ctl, C_IDLE);
    check("reset_fwd", fwd, 4'b0000);
    branch_taken = 1'b0; idle();
    #8 rst_n = 1'b1;
    cyc();

    // R0 producer never matches
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); #1;
    check("r0_prod", ctl, C_IDLE);
    cyc(); set_id(4'd0, 1'b1, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0); #1;
    check("r0_use", ctl, C_IDLE);
    cyc(); idle(); #1;
    check("r0_fwd", fwd, 4'b0000);

    // ALU producer then immediate consumer
    cyc(); cyc();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0); #1;
    check("add_r3", ctl, C_IDLE);
    cyc(); set_id(4'd3, 1'b1, 4'd4, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0); #1;
`ifdef HAZARD_CTRL_FWD_EN
    check("raw_nostall", ctl, C_IDLE);
    cyc(); idle(); #1;
    check("raw_fwd01", fwd, 4'b0100);
`else
    check("raw_stall0", ctl, C_STALL);
    cyc(); #1;
    check("raw_stall1", ctl, C_STALL);
    cyc(); #1;
    check("raw_go", ctl, C_IDLE);
    cyc(); idle(); #1;
    check("raw_fwd00", fwd, 4'b0000);
`endif

    // Load then consumer of both operands
    cyc(); cyc();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0); #1;
    check("lw", ctl, C_IDLE);
    cyc(); set_id(4'd5, 1'b1, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0); id_valid = 1'b0; #1;
    check("lu_invalid", ctl, C_IDLE);
    id_valid = 1'b1; #1;
    check("lu_stall", ctl, C_STALL);
`ifdef HAZARD_CTRL_FWD_EN
    cyc(); #1;
    check("lu_ldstall", ctl, C_IDLE);
    check("lu_fwd_bubble", fwd, 4'b0000);
    cyc(); idle(); #1;
    check("lu_fwd10", fwd, 4'b1010);
`else
    cyc(); #1;
    check("lu_stall_mem", ctl, C_STALL);
    cyc(); #1;
    check("lu_go", ctl, C_IDLE);
    cyc(); idle(); #1;
    check("lu_fwd00", fwd, 4'b0000);
`endif

    // Branch overrides a load-use stall; BRFLUSH ignores ID and branch
    cyc(); cyc();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0); #1;
    cyc(); set_id(4'd5, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0); branch_taken = 1'b1; #1;
    check("br_over_stall", ctl, C_FLUSH);
    cyc(); #1;
    check("brflush_ignore", ctl, C_IDLE);
    cyc(); idle(); #1;
    check("br_back_run", ctl, C_FLUSH);
    cyc(); branch_taken = 1'b0; #1;
    check("br_done", ctl, C_IDLE);

    // Branch aborts a drain in progress
    cyc();
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); #1;
    check("hlt_enter", ctl, C_STALL);
    cyc(); #1;
    check("drain_first", ctl, C_STALL);
    cyc(); branch_taken = 1'b1; #1;
    check("drain_abort", ctl, C_FLUSH);
    cyc(); branch_taken = 1'b0; idle(); #1;
    check("abort_flush", ctl, C_IDLE);
    repeat (4) cyc();
    #1;
    check("abort_no_halt", ctl, C_IDLE);

    // Full drain to HALTED, then reset
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); #1;
    check("hlt2_enter", ctl, C_STALL);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check($sformatf("drain%0d", i), ctl, C_STALL);
    end
    cyc(); #1;
    check("halted", ctl, C_HALT);
    branch_taken = 1'b1; #1;
    check("halted_ignore_br", ctl, C_HALT);
    cyc(); #1;
    check("halted_hold", ctl, C_HALT);
    rst_n = 1'b0; #1;
    check("rst_ctl", ctl, C_IDLE);
    check("rst_fwd", fwd, 4'b0000);
    branch_taken = 1'b0; idle();
    #2 rst_n = 1'b1;
    cyc(); branch_taken = 1'b1; #1;
    check("rst_run", ctl, C_FLUSH);
    cyc(); branch_taken = 1'b0; cyc();

    // Reset during a stall leaves no pending hazard
    set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0); #1;
    cyc(); set_id(4'd3, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0); #1;
    check("mid_stall", ctl, C_STALL);
    rst_n = 1'b0; #1;
    check("mid_rst", ctl, C_IDLE);
    #2 rst_n = 1'b1; #1;
    check("mid_resume", ctl, C_IDLE);
    cyc(); idle(); #1;
    check("mid_fwd", fwd, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
